// File: rtl/dw_mem_arbiter.sv
// Round-robin arbiter sharing one data-word memory port across N_CORES; request-to-ready >= 2 cycles, ACC waits on M_RDY.
// Optional macro ARB_LOCK_EN adds REQ_LOCK so a core can keep the port across back-to-back accesses (atomic RMW).
module dw_mem_arbiter #(
    parameter int N_CORES = 4,
    parameter int DA_W    = 16,
    parameter int DW_W    = 32
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic [N_CORES-1:0]        REQ_OE,
    input  logic [N_CORES-1:0]        REQ_WE,
    input  logic [N_CORES*DA_W-1:0]   REQ_A,
    input  logic [N_CORES*DW_W-1:0]   REQ_D,
`ifdef ARB_LOCK_EN
    input  logic [N_CORES-1:0]        REQ_LOCK,
`endif
    output logic [N_CORES-1:0]        REQ_RDY,
    output logic [DW_W-1:0]           RD_D,
    output logic [N_CORES-1:0]        GNT,
    output logic [DA_W-1:0]           M_A,
    output logic [DW_W-1:0]           M_D,
    output logic                      M_OE,
    output logic                      M_WE,
    input  logic                      M_RDY,
    input  logic [DW_W-1:0]           M_Q
);

    localparam int IW = $clog2(N_CORES);

    typedef enum logic {IDLE, ACC} state_t;

    state_t               state_q, state_d;
    logic [N_CORES-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [DA_W-1:0]      m_a_q, m_a_d;
    logic [DW_W-1:0]      m_d_q, m_d_d;
    logic                 m_oe_q, m_oe_d;
    logic                 m_we_q, m_we_d;
    logic [DW_W-1:0]      rd_d_q, rd_d_d;
`ifdef ARB_LOCK_EN
    logic                 lock_vld_q, lock_vld_d;
`endif

    logic [N_CORES-1:0]   req;
    logic                 found;
    logic [IW-1:0]        sel;
    int                   idx;

    // Scan starts just after the last-served core, wrapping at N_CORES.
    always_comb begin
        req   = REQ_OE | REQ_WE;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= N_CORES; k++) begin
            idx = (int'(ptr_q) + k) % N_CORES;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
`ifdef ARB_LOCK_EN
        // gidx_q still names the last-served core, which is the lock holder.
        if (lock_vld_q && req[gidx_q] && REQ_LOCK[gidx_q]) begin
            found = 1'b1;
            sel   = gidx_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        m_a_d   = m_a_q;
        m_d_d   = m_d_q;
        m_oe_d  = m_oe_q;
        m_we_d  = m_we_q;
        rd_d_d  = rd_d_q;
`ifdef ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_LOCK_EN
                lock_vld_d = 1'b0;
`endif
                if (found) begin
                    state_d = ACC;
                    gnt_d   = N_CORES'(1) << sel;
                    gidx_d  = sel;
                    m_a_d   = REQ_A[int'(sel)*DA_W +: DA_W];
                    m_d_d   = REQ_D[int'(sel)*DW_W +: DW_W];
                    m_we_d  = REQ_WE[sel];
                    m_oe_d  = REQ_OE[sel] & ~REQ_WE[sel];
                end
            end
            ACC: begin
                if (M_RDY) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    m_oe_d  = 1'b0;
                    m_we_d  = 1'b0;
                    ptr_d   = gidx_q;
                    if (m_oe_q) begin
                        rd_d_d = M_Q;
                    end
`ifdef ARB_LOCK_EN
                    if (REQ_LOCK[gidx_q]) begin
                        ptr_d      = ptr_q;
                        lock_vld_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(N_CORES - 1);
            m_a_q   <= '0;
            m_d_q   <= '0;
            m_oe_q  <= 1'b0;
            m_we_q  <= 1'b0;
            rd_d_q  <= '0;
`ifdef ARB_LOCK_EN
            lock_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            m_a_q   <= m_a_d;
            m_d_q   <= m_d_d;
            m_oe_q  <= m_oe_d;
            m_we_q  <= m_we_d;
            rd_d_q  <= rd_d_d;
`ifdef ARB_LOCK_EN
            lock_vld_q <= lock_vld_d;
`endif
        end
    end

    assign REQ_RDY = (state_q == ACC && M_RDY) ? gnt_q : '0;
    assign RD_D    = rd_d_q;
    assign GNT     = gnt_q;
    assign M_A     = m_a_q;
    assign M_D     = m_d_q;
    assign M_OE    = m_oe_q;
    assign M_WE    = m_we_q;

endmodule

// File: tb/tb_dw_mem_arbiter.sv
// Directed bench for dw_mem_arbiter: inputs driven 1ns after posedge, outputs checked mid-cycle.
module tb_dw_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic              clk;
    logic              clr;
    logic [N-1:0]      req_oe, req_we;
    logic [N*AW-1:0]   req_a;
    logic [N*DW-1:0]   req_d;
`ifdef ARB_LOCK_EN
    logic [N-1:0]      req_lock;
`endif
    logic [N-1:0]      req_rdy;
    logic [DW-1:0]     rd_d;
    logic [N-1:0]      gnt;
    logic [AW-1:0]     m_a;
    logic [DW-1:0]     m_d;
    logic              m_oe, m_we;
    logic              m_rdy;
    logic [DW-1:0]     m_q;

    int total = 0;
    int bad   = 0;

    dw_mem_arbiter #(.N_CORES(N), .DA_W(AW), .DW_W(DW)) dut (
        .CLK(clk), .CLR(clr),
        .REQ_OE(req_oe), .REQ_WE(req_we), .REQ_A(req_a), .REQ_D(req_d),
`ifdef ARB_LOCK_EN
        .REQ_LOCK(req_lock),
`endif
        .REQ_RDY(req_rdy), .RD_D(rd_d), .GNT(gnt),
        .M_A(m_a), .M_D(m_d), .M_OE(m_oe), .M_WE(m_we),
        .M_RDY(m_rdy), .M_Q(m_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; req_oe = '0; req_we = '0; req_a = '0; req_d = '0;
        m_rdy = 1'b0; m_q = '0;
`ifdef ARB_LOCK_EN
        req_lock = '0;
`endif
        step(); step();
        clr = 1'b0;
        #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_oe", 64'(m_oe), 64'h0);
        chk("rst_we", 64'(m_we), 64'h0);
        chk("rst_a", 64'(m_a), 64'h0);
        chk("rst_d", 64'(m_d), 64'h0);
        chk("rst_rdd", 64'(rd_d), 64'h0);
        chk("rst_rdy", 64'(req_rdy), 64'h0);

        // Core 2 single read, M_RDY in first ACC cycle
        req_oe = 4'b0100;
        req_a[2*AW +: AW] = 16'h0010;
        step();
        chk("c2_gnt", 64'(gnt), 64'h4);
        chk("c2_a", 64'(m_a), 64'h0010);
        chk("c2_oe", 64'(m_oe), 64'h1);
        chk("c2_we", 64'(m_we), 64'h0);
        chk("c2_rdy_pre", 64'(req_rdy), 64'h0);
        m_rdy = 1'b1; m_q = 32'hDEADBEEF;
        #1;
        chk("c2_rdy", 64'(req_rdy), 64'h4);
        step();
        req_oe = '0;
        #1;
        chk("c2_rdy_after", 64'(req_rdy), 64'h0);
        chk("c2_gnt_after", 64'(gnt), 64'h0);
        chk("c2_oe_after", 64'(m_oe), 64'h0);
        chk("c2_rdd", 64'(rd_d), 64'hDEADBEEF);

        // Reset, then all four cores read with M_RDY always high
        clr = 1'b1;
        step();
        clr = 1'b0;
        req_oe = 4'b1111;
        for (int k = 0; k < N; k++) begin
            step();
            chk("rr_gnt", 64'(gnt), 64'(1 << k));
            chk("rr_rdy", 64'(req_rdy), 64'(1 << k));
            m_q = 32'hA0 + 32'(k);
            step();
            req_oe[k] = 1'b0;
            #1;
            chk("rr_idle_gnt", 64'(gnt), 64'h0);
            chk("rr_idle_rdy", 64'(req_rdy), 64'h0);
            chk("rr_rdd", 64'(rd_d), 64'hA0 + 64'(k));
        end

        // Core 1 read+write together: write wins, RD_D untouched
        m_rdy = 1'b0;
        req_oe = 4'b0010; req_we = 4'b0010;
        req_a[1*AW +: AW] = 16'h00FF;
        req_d[1*DW +: DW] = 32'h12345678;
        step();
        chk("wr_gnt", 64'(gnt), 64'h2);
        chk("wr_we", 64'(m_we), 64'h1);
        chk("wr_oe", 64'(m_oe), 64'h0);
        chk("wr_d", 64'(m_d), 64'h12345678);
        chk("wr_a", 64'(m_a), 64'h00FF);
        m_rdy = 1'b1; m_q = 32'h55555555;
        #1;
        chk("wr_rdy", 64'(req_rdy), 64'h2);
        step();
        req_oe = '0; req_we = '0;
        #1;
        chk("wr_rdd", 64'(rd_d), 64'hA3);

        // Core 0 read with M_RDY held low for 5 cycles
        m_rdy = 1'b0;
        req_oe = 4'b0001;
        req_a[0 +: AW] = 16'h0042;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("wait_rdy", 64'(req_rdy), 64'h0);
            chk("wait_gnt", 64'(gnt), 64'h1);
            chk("wait_a", 64'(m_a), 64'h0042);
            if (i < 4) step();
        end
        step();
        m_rdy = 1'b1; m_q = 32'hCAFEF00D;
        #1;
        chk("wait_rdy6", 64'(req_rdy), 64'h1);
        step();
        req_oe = '0;
        #1;
        chk("wait_rdd", 64'(rd_d), 64'hCAFEF00D);

        // Core 3 in ACC, CLR pulsed mid-access
        m_rdy = 1'b0;
        req_oe = 4'b1000;
        step();
        chk("clr_gnt_pre", 64'(gnt), 64'h8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        req_oe = 4'b1001;
        m_rdy = 1'b1;
        #1;
        chk("clr_gnt", 64'(gnt), 64'h0);
        chk("clr_oe", 64'(m_oe), 64'h0);
        chk("clr_rdd", 64'(rd_d), 64'h0);
        chk("clr_rdy_idle", 64'(req_rdy), 64'h0);
        step();
        chk("clr_first_gnt", 64'(gnt), 64'h1);
        chk("clr_first_rdy", 64'(req_rdy), 64'h1);
        step();
        req_oe = 4'b1000;
        #1;

`ifdef ARB_LOCK_EN
        // Core 3 holds lock while core 0 also requests
        req_oe = 4'b1001;
        req_lock = 4'b1000;
        step();
        chk("lk_gnt1", 64'(gnt), 64'h8);
        step();
        chk("lk_idle", 64'(gnt), 64'h0);
        step();
        chk("lk_gnt2", 64'(gnt), 64'h8);
        req_lock = '0;
        req_oe = 4'b0001;
        step();
        step();
        chk("lk_gnt3", 64'(gnt), 64'h1);
        step();
`endif
        req_oe = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
